// File: rtl/axi_spi_flash_reader_if.sv
// AXI4-Lite read channels (AR + R) for the SPI flash reader.
// master drives araddr/arvalid/rready; slave drives arready/rdata/rresp/rvalid.
interface axi_spi_flash_reader_if;
  logic [23:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_spi_flash_reader.sv
// AXI4-Lite read-only slave: each read becomes one SPI mode-0 flash read.
// Ports: ACLK, ARESETn (sync, active-low), axi (AR/R slave), spi_sclk,
// spi_cs_n, spi_mosi, spi_miso. Macro SPI_FAST_READ_EN: 0x0B + 8 dummy bits.
module axi_spi_flash_reader #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  axi_spi_flash_reader_if.slave        axi,
  output logic                         spi_sclk,
  output logic                         spi_cs_n,
  output logic                         spi_mosi,
  input  logic                         spi_miso
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;

  localparam logic [6:0] CMD_END  = 7'd7;
  localparam logic [6:0] ADDR_END = 7'd31;

`ifdef SPI_FAST_READ_EN
  localparam logic [2:0] S_DUMMY   = 3'd3;
  localparam logic [6:0] DUMMY_END = 7'd39;
  localparam logic [6:0] LAST_BIT  = 7'd71;
  localparam logic [7:0] CMD       = 8'h0B;
  localparam logic [2:0] POST_ADDR = S_DUMMY;
`else
  localparam logic [6:0] LAST_BIT  = 7'd63;
  localparam logic [7:0] CMD       = 8'h03;
  localparam logic [2:0] POST_ADDR = S_DATA;
`endif

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [2:0]  state;
  logic [2:0]  nxt;
  logic [7:0]  div_cnt;
  logic [6:0]  bit_cnt;
  logic [31:0] tx_sr;
  logic [31:0] rx_sr;
  logic [31:0] rdata_q;
  logic        rvalid_q;
  logic        arready_q;
  logic        sclk_q;
  logic        cs_n_q;
  logic        mosi_q;
  logic        busy;
  logic        tick;

  assign axi.arready = arready_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = 2'b00;
  assign axi.rvalid  = rvalid_q;
  assign spi_sclk    = sclk_q;
  assign spi_cs_n    = cs_n_q;
  assign spi_mosi    = mosi_q;

  assign tick = (div_cnt == DIV_LAST);

`ifdef SPI_FAST_READ_EN
  assign busy = (state == S_CMD) || (state == S_ADDR) ||
                (state == S_DUMMY) || (state == S_DATA);
`else
  assign busy = (state == S_CMD) || (state == S_ADDR) ||
                (state == S_DATA);
`endif

  // Phase advance, applied on the falling SCLK edge that ends bit_cnt.
  always_comb begin
    nxt = state;
    unique case (1'b1)
      (bit_cnt == CMD_END):   nxt = S_ADDR;
      (bit_cnt == ADDR_END):  nxt = POST_ADDR;
`ifdef SPI_FAST_READ_EN
      (bit_cnt == DUMMY_END): nxt = S_DATA;
`endif
      default:                nxt = state;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
    end else if (state == S_IDLE) begin
      arready_q <= 1'b1;
      if (axi.arvalid && arready_q) begin
        arready_q <= 1'b0;
        state     <= S_CMD;
        cs_n_q    <= 1'b0;
        mosi_q    <= CMD[7];
        // Remaining command bits then address; zeros shift in behind.
        tx_sr     <= {CMD[6:0], axi.araddr, 1'b0};
        div_cnt   <= '0;
        bit_cnt   <= '0;
      end
    end else if (state == S_RESP) begin
      if (axi.rready) begin
        rvalid_q  <= 1'b0;
        arready_q <= 1'b1;
        state     <= S_IDLE;
      end
    end else if (busy) begin
      if (!tick) begin
        div_cnt <= div_cnt + 8'd1;
      end else begin
        div_cnt <= '0;
        if (!sclk_q) begin
          sclk_q <= 1'b1;
          if (state == S_DATA) begin
            rx_sr <= {rx_sr[30:0], spi_miso};
          end
        end else begin
          sclk_q <= 1'b0;
          if (bit_cnt == LAST_BIT) begin
            cs_n_q   <= 1'b1;
            mosi_q   <= 1'b0;
            rvalid_q <= 1'b1;
            rdata_q  <= rx_sr;
            state    <= S_RESP;
          end else begin
            bit_cnt <= bit_cnt + 7'd1;
            mosi_q  <= tx_sr[31];
            tx_sr   <= {tx_sr[30:0], 1'b0};
            state   <= nxt;
          end
        end
      end
    end else begin
      state <= S_IDLE;
    end
  end

endmodule

// File: tb/tb_axi_spi_flash_reader.sv
// Directed bench for axi_spi_flash_reader with a mode-0 flash model.
// Build with SPI_FAST_READ_EN to exercise the 0x0B fast-read frame.
module tb_axi_spi_flash_reader;

`ifdef SPI_FAST_READ_EN
  localparam int         CLK_DIV = 1;
  localparam int         NBITS   = 72;
  localparam int         HDR     = 40;
  localparam int         LAT     = 144;
  localparam logic [7:0] CMD     = 8'h0B;
`else
  localparam int         CLK_DIV = 2;
  localparam int         NBITS   = 64;
  localparam int         HDR     = 32;
  localparam int         LAT     = 256;
  localparam logic [7:0] CMD     = 8'h03;
`endif

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  logic spi_sclk;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso = 1'b0;

  axi_spi_flash_reader_if axi ();

  axi_spi_flash_reader #(.CLK_DIV(CLK_DIV)) dut (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .axi      (axi),
    .spi_sclk (spi_sclk),
    .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int ar_cnt = 0;
  int last_ar = 0;
  int last_r = 0;
  int rvalid_cyc = 0;

  always @(posedge ACLK) begin
    cyc = cyc + 1;
    if (axi.arvalid && axi.arready) begin
      ar_cnt = ar_cnt + 1;
      last_ar = cyc;
    end
    if (axi.rvalid && axi.rready) last_r = cyc;
    if (axi.rvalid) rvalid_cyc = rvalid_cyc + 1;
  end

  // Flash model: bytes 0..3 = DE AD BE EF, else low address byte + 0x11.
  logic [7:0]  fl_cmd;
  logic [23:0] fl_addr;
  logic [7:0]  fl_byte;
  int          fl_bits = 0;
  int          fl_d;
  int          sclk_rises = 0;
  int          mosi_errs = 0;

  function automatic logic [7:0] mem_byte(input int a);
    case (a)
      0:       return 8'hDE;
      1:       return 8'hAD;
      2:       return 8'hBE;
      3:       return 8'hEF;
      default: return 8'(a) + 8'h11;
    endcase
  endfunction

  always @(negedge spi_cs_n) begin
    fl_bits = 0;
    fl_cmd  = '0;
    fl_addr = '0;
  end

  always @(posedge spi_sclk) begin
    sclk_rises = sclk_rises + 1;
    if (!spi_cs_n) begin
      if (fl_bits < 8) fl_cmd = {fl_cmd[6:0], spi_mosi};
      else if (fl_bits < 32) fl_addr = {fl_addr[22:0], spi_mosi};
      else if (spi_mosi !== 1'b0) mosi_errs = mosi_errs + 1;
      fl_bits = fl_bits + 1;
    end
  end

  always @(negedge spi_sclk) begin
    if (!spi_cs_n && fl_bits >= HDR) begin
      fl_d = fl_bits - HDR;
      if (fl_d < 32) begin
        fl_byte  = mem_byte(int'(fl_addr) + fl_d / 8);
        spi_miso = fl_byte[7 - (fl_d % 8)];
      end
    end
  end

  task automatic start_read(input logic [23:0] a, output int t0);
    int n = 0;
    @(negedge ACLK);
    while (!axi.arready && n < 500) begin
      @(negedge ACLK);
      n++;
    end
    checks++;
    if (axi.arready !== 1'b1) begin
      errors++;
      $display("FAIL ar_wait: arready=%b required 1", axi.arready);
    end
    axi.araddr  = a;
    axi.arvalid = 1'b1;
    sclk_rises  = 0;
    mosi_errs   = 0;
    t0 = cyc + 1;
    @(negedge ACLK);
    axi.arvalid = 1'b0;
  endtask

  task automatic observe_read(input int t0, output int lat,
                              output logic [31:0] data,
                              output logic [1:0] resp);
    int n = 0;
    while (!axi.rvalid && n < 3000) begin
      @(negedge ACLK);
      n++;
    end
    lat  = axi.rvalid ? cyc - t0 : -1;
    data = axi.rdata;
    resp = axi.rresp;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge ACLK);
    checks++;
    if (axi.arready !== 1'b0 || axi.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rst_hs: arready=%b rvalid=%b required 0 0",
               axi.arready, axi.rvalid);
    end
    checks++;
    if (axi.rdata !== 32'h0 || axi.rresp !== 2'b00) begin
      errors++;
      $display("FAIL rst_r: rdata=%h rresp=%b required 0 0",
               axi.rdata, axi.rresp);
    end
    checks++;
    if ({spi_cs_n, spi_sclk, spi_mosi} !== 3'b100) begin
      errors++;
      $display("FAIL rst_spi: cs_n/sclk/mosi=%b required 100",
               {spi_cs_n, spi_sclk, spi_mosi});
    end
    ARESETn = 1'b1;
    @(negedge ACLK);
    checks++;
    if (axi.arready !== 1'b1) begin
      errors++;
      $display("FAIL rst_release: arready=%b required 1", axi.arready);
    end
  endtask

  task automatic test_basic();
    int t0, lat;
    logic [31:0] d;
    logic [1:0] r;
    axi.rready = 1'b1;
    start_read(24'h000000, t0);
    observe_read(t0, lat, d, r);
    checks++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL basic_lat: got %0d required %0d", lat, LAT);
    end
    checks++;
    if (d !== 32'hDEADBEEF || r !== 2'b00) begin
      errors++;
      $display("FAIL basic_data: got %h/%b required deadbeef/00", d, r);
    end
    checks++;
    if (fl_cmd !== CMD || fl_addr !== 24'h000000) begin
      errors++;
      $display("FAIL basic_frame: cmd %h addr %h required %h 000000",
               fl_cmd, fl_addr, CMD);
    end
    checks++;
    if (sclk_rises != NBITS || mosi_errs != 0) begin
      errors++;
      $display("FAIL basic_sclk: rises %0d mosi_errs %0d required %0d 0",
               sclk_rises, mosi_errs, NBITS);
    end
    @(negedge ACLK);
    checks++;
    if (axi.rvalid !== 1'b0 || axi.arready !== 1'b1) begin
      errors++;
      $display("FAIL basic_r_hs: rvalid=%b arready=%b required 0 1",
               axi.rvalid, axi.arready);
    end
  endtask

  task automatic test_back_to_back();
    int t0, t1, lat, ar0, n;
    logic [31:0] d;
    logic [1:0] r;
    axi.rready = 1'b1;
    ar0 = ar_cnt;
    start_read(24'h00000A, t0);
    axi.araddr  = 24'h000014;
    axi.arvalid = 1'b1;
    observe_read(t0, lat, d, r);
    sclk_rises = 0;
    mosi_errs  = 0;
    checks++;
    if (lat != LAT || d !== 32'h1B1C1D1E) begin
      errors++;
      $display("FAIL b2b_first: lat %0d data %h required %0d 1b1c1d1e",
               lat, d, LAT);
    end
    checks++;
    if (fl_addr !== 24'h00000A) begin
      errors++;
      $display("FAIL b2b_addr0: got %h required 00000a", fl_addr);
    end
    n = 0;
    while (ar_cnt < ar0 + 2 && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    axi.arvalid = 1'b0;
    t1 = last_ar;
    checks++;
    if (ar_cnt != ar0 + 2 || last_ar - last_r != 1) begin
      errors++;
      $display("FAIL b2b_gap: handshakes %0d gap %0d required 2 1",
               ar_cnt - ar0, last_ar - last_r);
    end
    observe_read(t1, lat, d, r);
    checks++;
    if (lat != LAT || d !== 32'h25262728) begin
      errors++;
      $display("FAIL b2b_second: lat %0d data %h required %0d 25262728",
               lat, d, LAT);
    end
    checks++;
    if (fl_addr !== 24'h000014 || sclk_rises != NBITS) begin
      errors++;
      $display("FAIL b2b_addr1: addr %h rises %0d required 000014 %0d",
               fl_addr, sclk_rises, NBITS);
    end
  endtask

  task automatic test_backpressure();
    int t0, lat, ar0;
    logic [31:0] d;
    logic [1:0] r;
    @(negedge ACLK);
    axi.rready = 1'b0;
    start_read(24'h000010, t0);
    ar0 = ar_cnt;
    observe_read(t0, lat, d, r);
    checks++;
    if (lat != LAT || d !== 32'h21222324) begin
      errors++;
      $display("FAIL bp_data: lat %0d data %h required %0d 21222324",
               lat, d, LAT);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      checks++;
      if (axi.rvalid !== 1'b1 || axi.rdata !== 32'h21222324 ||
          axi.arready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: rvalid=%b rdata=%h arready=%b req 1 21222324 0",
                 i, axi.rvalid, axi.rdata, axi.arready);
      end
      axi.araddr  = 24'h000030;
      axi.arvalid = i[0];
    end
    @(negedge ACLK);
    axi.arvalid = 1'b0;
    axi.rready  = 1'b1;
    @(negedge ACLK);
    checks++;
    if (axi.rvalid !== 1'b0 || axi.arready !== 1'b1 || ar_cnt != ar0) begin
      errors++;
      $display("FAIL bp_release: rvalid=%b arready=%b extra_ar=%0d req 0 1 0",
               axi.rvalid, axi.arready, ar_cnt - ar0);
    end
  endtask

  task automatic test_reset_mid();
    int t0, lat, rc0, n;
    logic [31:0] d;
    logic [1:0] r;
    axi.rready = 1'b1;
    start_read(24'h000000, t0);
    rc0 = rvalid_cyc;
    n = 0;
    while (!(fl_bits >= 31 && spi_sclk) && n < 500) begin
      @(negedge ACLK);
      n++;
    end
    ARESETn = 1'b0;
    @(posedge ACLK);
    #1;
    checks++;
    if (spi_cs_n !== 1'b1 || spi_sclk !== 1'b0 || axi.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_edge: cs_n=%b sclk=%b rvalid=%b required 1 0 0",
               spi_cs_n, spi_sclk, axi.rvalid);
    end
    @(negedge ACLK);
    ARESETn = 1'b1;
    repeat (LAT + 20) @(negedge ACLK);
    checks++;
    if (rvalid_cyc != rc0) begin
      errors++;
      $display("FAIL midrst_norvalid: rvalid cycles %0d required 0",
               rvalid_cyc - rc0);
    end
    start_read(24'h000004, t0);
    observe_read(t0, lat, d, r);
    checks++;
    if (lat != LAT || d !== 32'h15161718 || fl_addr !== 24'h000004) begin
      errors++;
      $display("FAIL midrst_next: lat %0d data %h addr %h req %0d 15161718 000004",
               lat, d, fl_addr, LAT);
    end
  endtask

`ifdef SPI_FAST_READ_EN
  task automatic test_fast_read();
    int t0, lat;
    logic [31:0] d;
    logic [1:0] r;
    axi.rready = 1'b1;
    start_read(24'h0004FE, t0);
    observe_read(t0, lat, d, r);
    checks++;
    if (fl_cmd !== 8'h0B || sclk_rises != 72 || lat != 144) begin
      errors++;
      $display("FAIL fast_frame: cmd %h rises %0d lat %0d required 0b 72 144",
               fl_cmd, sclk_rises, lat);
    end
    checks++;
    if (d !== 32'h0F101112 || fl_addr !== 24'h0004FE) begin
      errors++;
      $display("FAIL fast_data: data %h addr %h required 0f101112 0004fe",
               d, fl_addr);
    end
  endtask
`endif

  initial begin
    axi.araddr  = '0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef SPI_FAST_READ_EN
    test_fast_read();
`endif
    repeat (4) @(negedge ACLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_spi_flash_reader.md
AXI_SPI_FLASH_READER -- requirements
Module: axi_spi_flash_reader

Interface
- REQ-001: The block SHALL have parameter CLK_DIV, default 2, giving the SCLK half-period in ACLK cycles (legal range 1..255).
- REQ-002: The block SHALL have port ACLK, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-003: The block SHALL have port ARESETn, input, 1 bit: the reset, synchronous and active-low.
- REQ-004: The block SHALL have port araddr, input, 24 bits: the flash byte address.
- REQ-005: The block SHALL have port arvalid, input, 1 bit: the read address is valid.
- REQ-006: The block SHALL have port arready, output, 1 bit: the block accepts an address.
- REQ-007: The block SHALL have port rdata, output, 32 bits: the read word.
- REQ-008: The block SHALL have port rresp, output, 2 bits: the read response, always 2'b00 (OKAY).
- REQ-009: The block SHALL have port rvalid, output, 1 bit: read data is valid.
- REQ-010: The block SHALL have port rready, input, 1 bit: the master accepts the read data.
- REQ-011: The block SHALL have port spi_sclk, output, 1 bit: the SPI clock, mode 0, idling low.
- REQ-012: The block SHALL have port spi_cs_n, output, 1 bit: the flash chip select, active-low.
- REQ-013: The block SHALL have port spi_mosi, output, 1 bit: serial data to the flash.
- REQ-014: The block SHALL have port spi_miso, input, 1 bit: serial data from the flash.

Function
- REQ-015: The block SHALL be an AXI4-Lite read-only slave that serves each accepted read with one SPI flash read transaction.
- REQ-016: The block SHALL implement the FSM IDLE -> CMD -> ADDR -> [DUMMY] -> DATA -> RESP -> IDLE.
- REQ-017: In IDLE the block SHALL drive arready=1; in every other state it SHALL drive arready=0, and arvalid outside IDLE SHALL be ignored.
- REQ-018: On the AR handshake edge T, the block SHALL capture araddr verbatim with no alignment check, drive spi_cs_n=0, and drive spi_mosi = command bit 7.
- REQ-019: The serial frame SHALL be the 8-bit command 0x03, then the 24-bit address, then 32 data bits, all MSB first; N = 64 bits in total.
- REQ-020: For bit k (0..N-1), spi_sclk SHALL rise at T+(2k+1)*CLK_DIV and fall at T+(2k+2)*CLK_DIV.
- REQ-021: spi_mosi SHALL update only on falling edges; spi_miso SHALL be sampled on rising edges.
- REQ-022: During data bits spi_mosi SHALL be 0.
- REQ-023: The first data bit received SHALL land in rdata[31] and the last in rdata[0].
- REQ-024: At edge T+2N*CLK_DIV the block SHALL drive spi_cs_n=1, spi_sclk=0, and rvalid=1, and enter RESP.
- REQ-025: In RESP, rdata and rvalid SHALL be held stable until rvalid&&rready.
- REQ-026: On the R handshake edge the block SHALL drive rvalid=0 and enter IDLE, with arready=1 on the next cycle.
- REQ-027: If rready is already high when rvalid rises, the handshake SHALL complete in that cycle.
- REQ-028: A new transaction SHALL be able to start the cycle after returning to IDLE.
- REQ-029: rdata SHALL update only at RESP entry.

Reset
- REQ-030: While ARESETn=0 at a rising ACLK edge, the block SHALL drive arready=0, rvalid=0, rdata=0, rresp=0, spi_cs_n=1, spi_sclk=0, spi_mosi=0, and state IDLE.
- REQ-031: arready SHALL go to 1 on the first edge with ARESETn=1.
- REQ-032: A reset asserted mid-transfer SHALL abort the transfer: spi_cs_n=1 and spi_sclk=0 at the reset edge, with no rvalid for the aborted read.

Configuration
- REQ-033: The block SHALL support the macro SPI_FAST_READ_EN.
- REQ-034: With SPI_FAST_READ_EN defined, the command SHALL be 0x0B followed by 8 dummy bits (mosi=0, miso ignored) between address and data, giving N = 72.
- REQ-035: Without SPI_FAST_READ_EN, the command SHALL be 0x03 with no dummy state and N = 64.

Verification
- REQ-036: Scenario basic read: flash model bytes 0xDE,0xAD,0xBE,0xEF at 0x000000, CLK_DIV=2, araddr=0x000000 with rready held 1 -> mosi frame 0x03,0x00,0x00,0x00; 64 sclk rising edges; rvalid high exactly 256 cycles after handshake; rdata=0xDEADBEEF; rresp=0.
- REQ-037: Scenario unaligned and back-to-back: araddr=0x00000A, then 0x000014 presented as soon as arready returns -> each mosi address field matches verbatim; second handshake occurs exactly 1 cycle after the first R handshake.
- REQ-038: Scenario backpressure: rready held 0 for 20 cycles after rvalid -> rvalid and rdata stable for 20 cycles, arready=0 throughout, and arvalid pulses ignored.
- REQ-039: Scenario reset mid-transfer: ARESETn=0 for 1 cycle at bit 30 -> spi_cs_n=1 and spi_sclk=0 at the reset edge; no rvalid; the next read at 0x000004 returns correct data.
- REQ-040: Scenario SPI_FAST_READ_EN defined, CLK_DIV=1, araddr=0x0004FE -> command 0x0B and 72 sclk edges; rvalid exactly 144 cycles after handshake; rdata equals the model bytes at 0x4FE..0x501.
